word_serializer: RTL and testbench
==================================

# word_serializer

Parallel-to-serial feeder placed directly upstream of the Mealy sequence detector. It accepts WIDTH-bit words over a valid/ready handshake and drives them one bit per clock onto the detector's serial input `x`, with a qualifying strobe. A one-entry holding register lets back-to-back words stream without idle bits. An optional even-parity bit can be appended after each word.

## Interface
- `WIDTH`, 8: data bits per word; legal range 2..32.
- `MSB_FIRST`, 1: 1 = bit WIDTH-1 is shifted first; 0 = bit 0 is shifted first.
- `IDLE_BIT`, 0: value driven on `x` whenever `x_valid` = 0.

- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the rising edge of `clock`.
- `in_data`  in  WIDTH  word to serialize.
- `in_valid`  in  1  `in_data` is valid.
- `in_ready`  out  1  hold register is empty; a word is accepted on an edge where `in_valid` && `in_ready`.
- `x`  out  1  serial bit for the detector; registered.
- `x_valid`  out  1  `x` carries a data bit or parity bit this cycle; registered.
- `word_done`  out  1  one-cycle pulse coinciding with the final serial bit of a word.
- `busy`  out  1  high when the hold register is valid or the state is not IDLE.

## Operation
- States:
  - IDLE: no bits being shifted.
  - SHIFT: data bits being driven.
  - PARITY: exists only with `SER_PARITY_EN`.
- Hold register: `hold_valid`/`hold_data`.
  - `in_ready` = !`hold_valid`, purely combinational from the register.
  - An accepted word is written into hold.
- Load from hold into the shift register happens on an edge where `hold_valid` = 1 and either:
  - the state is IDLE, or
  - the current cycle is the final serial bit of a word.
- A load clears `hold_valid` unless a new word is accepted on the same edge. That case cannot occur, because `in_ready` = 0 while hold is full.
- SHIFT:
  - `x` = shift-register bit selected by `MSB_FIRST`; the register shifts each edge.
  - A bit counter runs 0..WIDTH-1.
- End of a word's bits: go to SHIFT with the new word if hold is loaded, otherwise go to IDLE.
- IDLE: `x` = `IDLE_BIT`, `x_valid` = 0.
- `in_valid` may drop or change while `in_ready` = 0 without effect. Words are never duplicated or dropped.

## Timing
- Reset values: `x` = `IDLE_BIT`, `x_valid` = 0, `word_done` = 0, `busy` = 0, `hold_valid` = 0, so `in_ready` = 1 in the first cycle after reset.
- Handshakes presented while `reset` = 1 are ignored.
- Reset mid-word discards the shifting word and the held word. No partial word resumes.
- Latency: word accepted at edge N → loaded at edge N+1 → first bit visible on `x` in the cycle after edge N+1.
- Each bit is held for exactly one clock, so the detector samples it on the following edge.
- Throughput: continuous. A held word's first bit immediately follows the previous word's last bit, with no `x_valid` gap.
- `word_done`: asserted in the same cycle as the last serial bit, which is data bit WIDTH-1 or the parity bit.

## Configuration
- `SER_PARITY_EN` defined:
  - After the last data bit, one PARITY cycle drives `x` = XOR of all WIDTH data bits (even parity) with `x_valid` = 1.
  - `word_done` pulses in the PARITY cycle.
  - A word occupies WIDTH+1 cycles.
- `SER_PARITY_EN` not defined:
  - No PARITY state or parity logic.
  - A word occupies WIDTH cycles and `word_done` pulses with the last data bit.

## Structure
- Shared package `ser_pkg` holds:
  - the state encoding constants (IDLE, SHIFT, PARITY);
  - the default WIDTH constant;
  - the bit-counter width, derived as clog2(WIDTH+1).
- One sub-module: `word_hold_reg`, the one-entry holding buffer with valid/ready handshake and load/clear interface.
- The shift register, counter and FSM live in `word_serializer`.

## Test plan
All scenarios use WIDTH=8, MSB_FIRST=1, IDLE_BIT=0 unless stated otherwise.
- Reset, then 8'hE3 with valid for one cycle → `x` = 1,1,1,0,0,0,1,1 on 8 consecutive `x_valid` cycles; `word_done` in the 8th; afterwards `x` = 0, `x_valid` = 0, `busy` = 0.
- 8'hE3 then 8'h3C, with `in_valid` held → 16 contiguous `x_valid` cycles with no gap; `in_ready` low while 8'h3C waits in hold; two `word_done` pulses, 8 cycles apart.
- `in_valid` held high with constant data while `in_ready` = 0 for 7 cycles → word serialized exactly once.
- `reset` asserted during bit 4 of 8'hE3 → next cycle `x` = 0, `x_valid` = 0, `in_ready` = 1; the following word 8'hA5 serializes cleanly as 1,0,1,0,0,1,0,1.
- `SER_PARITY_EN` with 8'hE3 → 9th bit = 1; with 8'h3C → 9th bit = 0; `word_done` on the 9th bit.
- MSB_FIRST=0 with 8'hE3 → `x` = 1,1,0,0,0,1,1,1.

Source files
------------

// File: rtl/ser_pkg.sv
// ser_pkg: shared definitions for the word serializer slice.
//   ser_state_e   : FSM encoding (IDLE, SHIFT, PARITY)
//   SER_WIDTH_DEF : default word width
//   ser_cnt_w()   : bit-counter width for a given word width, clog2(WIDTH+1)
package ser_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_PARITY = 2'd2
  } ser_state_e;

  localparam int SER_WIDTH_DEF = 8;

  function automatic int ser_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/word_serializer_if.sv
// word_serializer_if: word input handshake plus serial output bundle.
//   in_data/in_valid/in_ready : word handshake (producer -> serializer)
//   x/x_valid                 : serial bit and its qualifier (serializer -> detector)
//   word_done                 : pulse with the last serial bit of a word
//   busy                      : hold register occupied or FSM not idle
// modport slave is the serializer side, master the producer/observer side.
interface word_serializer_if
  import ser_pkg::*;
#(
  parameter int WIDTH = SER_WIDTH_DEF
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             x;
  logic             x_valid;
  logic             word_done;
  logic             busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, x, x_valid, word_done, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, x, x_valid, word_done, busy
  );
endinterface

// File: rtl/word_hold_reg.sv
// word_hold_reg: one-entry holding buffer in front of the shift register.
//   clock, reset     : clock, synchronous active-high reset
//   in_data/in_valid : incoming word and its valid
//   in_ready         : buffer empty (combinational from the valid flop)
//   clear            : consumer took the held word this edge
//   hold_valid/data  : held word
module word_hold_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             clear,
  output logic             hold_valid,
  output logic [WIDTH-1:0] hold_data
);
  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;

  assign in_ready   = !valid_q;
  assign accept     = in_valid && in_ready;
  assign hold_valid = valid_q;
  assign hold_data  = data_q;

  // clear only happens while full and accept only while empty, so they
  // never coincide; accept is still given priority for clarity.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (clear) valid_d = 1'b0;
    if (accept) begin
      valid_d = 1'b1;
      data_d  = in_data;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end
endmodule

// File: rtl/word_serializer.sv
// word_serializer: parallel-to-serial feeder for the sequence detector.
// Words enter through a one-entry hold register and are shifted out one bit
// per clock on x/x_valid. The next held word loads on the edge that ends the
// current word, so back-to-back words stream with no idle bit.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : in_data/in_valid/in_ready, x, x_valid, word_done, busy
// Parameters: WIDTH (2..32), MSB_FIRST (1: bit WIDTH-1 first), IDLE_BIT
// (x value while x_valid=0).
// Build option: define SER_PARITY_EN to append an even-parity bit per word.
module word_serializer
  import ser_pkg::*;
#(
  parameter int WIDTH     = SER_WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic               clock,
  input logic               reset,
  word_serializer_if.slave  bus
);
  localparam int             CW       = ser_cnt_w(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);

  ser_state_e       state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d, sh_next;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             x_q, x_d;
  logic             xv_q, xv_d;
  logic             hold_valid;
  logic [WIDTH-1:0] hold_data;
  logic             final_bit;
  logic             load;
`ifdef SER_PARITY_EN
  logic             par_q, par_d;
`endif

  // Bit that goes out first from a word image.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clock      (clock),
    .reset      (reset),
    .in_data    (bus.in_data),
    .in_valid   (bus.in_valid),
    .in_ready   (bus.in_ready),
    .clear      (load),
    .hold_valid (hold_valid),
    .hold_data  (hold_data)
  );

  // Move the next bit into the lead position.
  always_comb begin
    if (MSB_FIRST) sh_next = {sh_q[WIDTH-2:0], 1'b0};
    else           sh_next = {1'b0, sh_q[WIDTH-1:1]};
  end

  // The cycle currently on x is the last bit of its word.
  always_comb begin
`ifdef SER_PARITY_EN
    final_bit = (state_q == ST_PARITY);
`else
    final_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_IDX);
`endif
  end

  // Loading on the final-bit edge is what keeps x_valid gap-free.
  assign load = hold_valid && ((state_q == ST_IDLE) || final_bit);

  // x/x_valid are registered: the bit computed here appears after the edge.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    x_d     = IDLE_BIT;
    xv_d    = 1'b0;
`ifdef SER_PARITY_EN
    par_d   = par_q;
`endif
    if (load) begin
      state_d = ST_SHIFT;
      sh_d    = hold_data;
      cnt_d   = '0;
      x_d     = lead_bit(hold_data);
      xv_d    = 1'b1;
`ifdef SER_PARITY_EN
      par_d   = ^hold_data;
`endif
    end else begin
      case (state_q)
        ST_SHIFT: begin
          if (cnt_q != LAST_IDX) begin
            sh_d  = sh_next;
            cnt_d = cnt_q + 1'b1;
            x_d   = lead_bit(sh_next);
            xv_d  = 1'b1;
          end else begin
`ifdef SER_PARITY_EN
            state_d = ST_PARITY;
            x_d     = par_q;
            xv_d    = 1'b1;
`else
            state_d = ST_IDLE;
`endif
          end
        end
        // IDLE with nothing held stays idle; PARITY without a follow-on
        // word returns to idle.
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      sh_q    <= '0;
      cnt_q   <= '0;
      x_q     <= IDLE_BIT;
      xv_q    <= 1'b0;
`ifdef SER_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      xv_q    <= xv_d;
`ifdef SER_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign bus.x         = x_q;
  assign bus.x_valid   = xv_q;
  assign bus.word_done = final_bit;
  assign bus.busy      = hold_valid || (state_q != ST_IDLE);

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: two instances share one input stream, one
// MSB-first with IDLE_BIT=0, one LSB-first with IDLE_BIT=1. A background
// monitor turns every accepted word into its expected bit stream and checks
// both serial outputs bit by bit; directed steps check timing properties.
module tb_word_serializer;
  localparam int W = 8;
`ifdef SER_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L = W + PB;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  word_serializer_if #(.WIDTH(W)) b0 ();
  word_serializer_if #(.WIDTH(W)) b1 ();
  assign b1.in_data  = b0.in_data;
  assign b1.in_valid = b0.in_valid;

  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut0 (
    .clock(clock), .reset(reset), .bus(b0));
  word_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1)) dut1 (
    .clock(clock), .reset(reset), .bus(b1));

  int checks = 0;
  int errors = 0;
  // {last, lsb-first bit, msb-first bit} for every expected serial cycle
  logic [2:0] exq[$];
  int run;
  int wdq[$];
  int n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void push_word(input logic [W-1:0] d);
    for (int i = 0; i < W; i++)
      exq.push_back({(PB == 0) && (i == W - 1), d[i], d[W-1-i]});
    if (PB != 0) exq.push_back({1'b1, ^d, ^d});
  endfunction

  task automatic mon();
    logic [2:0] e;
    forever begin
      @(negedge clock);
      chk("xv_lanes", b1.x_valid, b0.x_valid);
      if (b0.x_valid === 1'b1) begin
        chk("extra_bit", 32'(exq.size() != 0), 1);
        if (exq.size() != 0) begin
          e = exq.pop_front();
          chk("x_msb", b0.x, e[0]);
          chk("x_lsb", b1.x, e[1]);
          chk("wd_msb", b0.word_done, e[2]);
          chk("wd_lsb", b1.word_done, e[2]);
        end
      end else begin
        chk("idle_x0", b0.x, 0);
        chk("idle_x1", b1.x, 1);
        chk("idle_wd", {b0.word_done, b1.word_done}, 0);
      end
      if (reset) exq.delete();
      else if (b0.in_valid && b0.in_ready) push_word(b0.in_data);
    end
  endtask

  // Called at posedge+1. Presents d once the hold register is free; while
  // waiting either holds d steady or drives random junk. nw = wait cycles.
  task automatic send(input logic [W-1:0] d, input bit noise, output int nw);
    nw = 0;
    while (!b0.in_ready && nw < 100) begin
      b0.in_valid = noise ? 1'($urandom_range(0, 1)) : 1'b1;
      b0.in_data  = noise ? W'($urandom) : d;
      @(posedge clock); #1;
      nw++;
    end
    chk("send_timeout", 32'(nw < 100), 1);
    b0.in_valid = 1'b1;
    b0.in_data  = d;
    @(posedge clock); #1;
    b0.in_valid = 1'b0;
    b0.in_data  = W'($urandom);
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while ((b0.busy || b0.x_valid) && k < 200) begin
      @(posedge clock); #1;
      k++;
    end
    chk(tag, 32'(k < 200), 1);
  endtask

  initial begin
    b0.in_valid = 1'b0;
    b0.in_data  = '0;
    repeat (2) @(posedge clock);
    #1;
    fork
      mon();
      begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
      end
    join_none

    // reset state
    chk("rst_x0", b0.x, 0);
    chk("rst_x1", b1.x, 1);
    chk("rst_xv", b0.x_valid, 0);
    chk("rst_wd", b0.word_done, 0);
    chk("rst_busy", b0.busy, 0);
    chk("rst_ready", b0.in_ready, 1);
    reset = 1'b0;

    // single word: L contiguous bits starting the cycle after the load edge
    send(8'hE3, 1'b0, n);
    @(posedge clock); #1;
    for (int i = 0; i < L; i++) begin
      chk("t1_xv", b0.x_valid, 1);
      chk("t1_wd", b0.word_done, 32'(i == L - 1));
      @(posedge clock); #1;
    end
    chk("t1_end_xv", b0.x_valid, 0);
    chk("t1_end_x", b0.x, 0);
    chk("t1_end_busy", b0.busy, 0);

    // back-to-back words with in_valid held
    b0.in_valid = 1'b1;
    b0.in_data  = 8'hE3;
    @(posedge clock); #1;
    chk("t2_ready_full", b0.in_ready, 0);
    b0.in_data = 8'h3C;
    @(posedge clock); #1;
    chk("t2_ready_free", b0.in_ready, 1);
    run = 0;
    wdq.delete();
    for (int i = 0; i < 2 * L + 1; i++) begin
      if (i == 1) begin
        chk("t2_hold_wait", b0.in_ready, 0);
        b0.in_valid = 1'b0;
      end
      if (b0.x_valid && run == i) run++;
      if (b0.word_done) wdq.push_back(i);
      @(posedge clock); #1;
    end
    chk("t2_contig", run, 2 * L);
    chk("t2_wd_count", wdq.size(), 2);
    chk("t2_wd_first", wdq[0], L - 1);
    chk("t2_wd_second", wdq[1], 2 * L - 1);

    // valid held with constant data through a long not-ready stretch
    send(8'h5A, 1'b0, n);
    send(8'h81, 1'b0, n);
    send(8'hC7, 1'b0, n);
    chk("t3_wait_cycles", n, L - 1);
    drain("t3_drain");
    chk("t3_queue_empty", exq.size(), 0);

    // reset in the middle of a word, with a handshake offered during reset
    send(8'hE3, 1'b0, n);
    repeat (5) begin @(posedge clock); #1; end
    reset       = 1'b1;
    b0.in_valid = 1'b1;
    b0.in_data  = 8'h5A;
    @(posedge clock); #1;
    chk("t4_x", b0.x, 0);
    chk("t4_xv", b0.x_valid, 0);
    chk("t4_ready", b0.in_ready, 1);
    chk("t4_busy", b0.busy, 0);
    reset       = 1'b0;
    b0.in_valid = 1'b0;
    @(posedge clock); #1;
    chk("t4_still_idle", b0.busy, 0);
    send(8'hA5, 1'b0, n);
    drain("t4_drain");
    chk("t4_queue_empty", exq.size(), 0);

    // random words, random gaps, junk on the inputs while not ready
    for (int w = 0; w < 40; w++) begin
      repeat ($urandom_range(0, 2)) begin
        b0.in_valid = 1'b0;
        b0.in_data  = W'($urandom);
        @(posedge clock); #1;
      end
      send(W'($urandom), 1'b1, n);
    end
    drain("t5_drain");
    chk("t5_queue_empty", exq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
